// File: rtl/pc_fetch_queue.sv
// Fetch PC, ROM request issue and a credit-checked (address, instruction) queue.
// Optional FETCH_STATS_EN adds stallCycles / flushCount counters.
module pc_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int PC_STEP = 4
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       PCWrite,
  input  logic                       redirectValid,
  input  logic [ADDR_W-1:0]          redirectAddress,
  output logic                       romEnable,
  output logic [ADDR_W-1:0]          romAddress,
  input  logic [INSTR_W-1:0]         romData,
  output logic [ADDR_W-1:0]          currentAddress,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [ADDR_W-1:0]          outAddress,
  output logic [INSTR_W-1:0]         outInstr,
`ifdef FETCH_STATS_EN
  output logic [31:0]                stallCycles,
  output logic [15:0]                flushCount,
`endif
  output logic [$clog2(DEPTH):0]     queueCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]  pc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_addr;
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [CW-1:0]      count;
  logic [ADDR_W-1:0]  qaddr  [DEPTH];
  logic [INSTR_W-1:0] qinstr [DEPTH];

  logic               push;
  logic               pop;
  logic [CW:0]        occ;

  assign outValid = (count != '0);
  assign pop      = outValid & outReady;
  assign push     = Reset & inflight & ~redirectValid;

  // Credits: entries held plus the response still in flight, minus what leaves now
  assign occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

  assign romEnable = Reset & PCWrite & ~redirectValid
                   & (occ < (CW+1)'(DEPTH));

  assign romAddress     = pc;
  assign currentAddress = pc;
  assign queueCount     = count;
  assign outAddress     = outValid ? qaddr[rptr]  : '0;
  assign outInstr       = outValid ? qinstr[rptr] : '0;

  always_ff @(posedge CLK) begin
    if (push) begin
      qaddr[wptr]  <= inflight_addr;
      qinstr[wptr] <= romData;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pc            <= RESET_ADDR;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
    end else begin
      inflight <= romEnable;
      if (romEnable)
        inflight_addr <= pc;
      if (redirectValid) begin
        pc    <= redirectAddress;
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (romEnable)
          pc <= pc + ADDR_W'(PC_STEP);
        if (push)
          wptr <= wptr + PW'(1);
        if (pop)
          rptr <= rptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (PCWrite & ~redirectValid & ~romEnable)
        stallCycles <= stallCycles + 32'd1;
      if (redirectValid)
        flushCount <= flushCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_queue.sv
// Directed bench for pc_fetch_queue (DEPTH=4) with a 1-cycle ROM model.
// A second instance checks PC wrap from RESET_ADDR=FFFF_FFF8.
module tb_pc_fetch_queue;

  logic        CLK;
  logic        Reset;
  logic        PCWrite;
  logic        redirectValid;
  logic [31:0] redirectAddress;
  logic        outReady;

  logic        romEnable;
  logic [31:0] romAddress;
  logic [31:0] romData;
  logic [31:0] currentAddress;
  logic        outValid;
  logic [31:0] outAddress;
  logic [31:0] outInstr;
  logic [2:0]  queueCount;

  logic        rom2En;
  logic [31:0] rom2Addr;
  logic [31:0] rom2Data;
  logic [31:0] cur2;
  logic        out2Valid;
  logic [31:0] out2Addr;
  logic [31:0] out2Instr;
  logic [2:0]  q2Count;

`ifdef FETCH_STATS_EN
  logic [31:0] stallCycles;
  logic [15:0] flushCount;
  logic [31:0] stall2;
  logic [15:0] flush2;
`endif

  int checks = 0;
  int errors = 0;

  pc_fetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4),
    .RESET_ADDR(32'h0), .PC_STEP(4)
  ) dut (
    .CLK(CLK),
    .Reset(Reset),
    .PCWrite(PCWrite),
    .redirectValid(redirectValid),
    .redirectAddress(redirectAddress),
    .romEnable(romEnable),
    .romAddress(romAddress),
    .romData(romData),
    .currentAddress(currentAddress),
    .outValid(outValid),
    .outReady(outReady),
    .outAddress(outAddress),
    .outInstr(outInstr),
`ifdef FETCH_STATS_EN
    .stallCycles(stallCycles),
    .flushCount(flushCount),
`endif
    .queueCount(queueCount)
  );

  pc_fetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4),
    .RESET_ADDR(32'hFFFF_FFF8), .PC_STEP(4)
  ) dut2 (
    .CLK(CLK),
    .Reset(Reset),
    .PCWrite(PCWrite),
    .redirectValid(redirectValid),
    .redirectAddress(redirectAddress),
    .romEnable(rom2En),
    .romAddress(rom2Addr),
    .romData(rom2Data),
    .currentAddress(cur2),
    .outValid(out2Valid),
    .outReady(outReady),
    .outAddress(out2Addr),
    .outInstr(out2Instr),
`ifdef FETCH_STATS_EN
    .stallCycles(stall2),
    .flushCount(flush2),
`endif
    .queueCount(q2Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (romEnable) romData <= romAddress ^ 32'hA5A5_0000;
    if (rom2En)    rom2Data <= rom2Addr ^ 32'hA5A5_0000;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    PCWrite = 1'b0;
    outReady = 1'b0;
    redirectValid = 1'b0;
    redirectAddress = '0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    PCWrite = 1'b1;
    #1;
    checks++;
    if (queueCount !== 3'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", queueCount);
    end
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", outValid);
    end
    checks++;
    if (romEnable !== 1'b0) begin
      errors++;
      $display("FAIL reset_romen got %b want 0", romEnable);
    end
    checks++;
    if (outAddress !== 32'h0 || outInstr !== 32'h0) begin
      errors++;
      $display("FAIL reset_head got %h/%h want 0/0",
               outAddress, outInstr);
    end
    checks++;
    if (currentAddress !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc got %h want 0", currentAddress);
    end
    checks++;
    if (cur2 !== 32'hFFFF_FFF8 || q2Count !== 3'd0) begin
      errors++;
      $display("FAIL reset_pc2 got %h/%0d want fffffff8/0",
               cur2, q2Count);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (stallCycles !== 32'd0 || flushCount !== 16'd0
        || stall2 !== 32'd0 || flush2 !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d want 0/0",
               stallCycles, flushCount);
    end
`endif
  endtask

  task automatic test_stream();
    logic [31:0] ea;
    do_reset();
    Reset = 1'b1;
    PCWrite = 1'b1;
    outReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (romEnable !== 1'b1 || romAddress !== 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_issue%0d got %b/%h want 1/%h",
                 k, romEnable, romAddress, 32'(4 * k));
      end
      if (k >= 2) begin
        ea = 32'(4 * (k - 2));
        checks++;
        if (outValid !== 1'b1 || outAddress !== ea
            || outInstr !== (ea ^ 32'hA5A5_0000)) begin
          errors++;
          $display("FAIL stream_out%0d got %b/%h/%h want 1/%h/%h",
                   k, outValid, outAddress, outInstr,
                   ea, ea ^ 32'hA5A5_0000);
        end
      end else begin
        checks++;
        if (outValid !== 1'b0) begin
          errors++;
          $display("FAIL stream_lat%0d got %b want 0", k, outValid);
        end
      end
      tick();
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (stallCycles !== 32'd0) begin
      errors++;
      $display("FAIL stream_stall got %0d want 0", stallCycles);
    end
`endif
  endtask

  task automatic test_full();
`ifdef FETCH_STATS_EN
    logic [31:0] s0;
`endif
    do_reset();
    Reset = 1'b1;
    PCWrite = 1'b1;
    outReady = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (queueCount !== 3'd4 || romEnable !== 1'b0
        || currentAddress !== 32'h10) begin
      errors++;
      $display("FAIL full_hold got %0d/%b/%h want 4/0/00000010",
               queueCount, romEnable, currentAddress);
    end
`ifdef FETCH_STATS_EN
    s0 = stallCycles;
`endif
    tick();
    tick();
    tick();
    checks++;
    if (queueCount !== 3'd4 || outAddress !== 32'h0) begin
      errors++;
      $display("FAIL full_stable got %0d/%h want 4/0",
               queueCount, outAddress);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (stallCycles - s0 !== 32'd3) begin
      errors++;
      $display("FAIL full_stall got %0d want 3", stallCycles - s0);
    end
`endif
    outReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (outValid !== 1'b1 || outAddress !== 32'(4 * k)) begin
        errors++;
        $display("FAIL full_drain%0d got %b/%h want 1/%h",
                 k, outValid, outAddress, 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    Reset = 1'b1;
    PCWrite = 1'b1;
    outReady = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (queueCount !== 3'd2) begin
      errors++;
      $display("FAIL redir_pre got %0d want 2", queueCount);
    end
    redirectValid = 1'b1;
    redirectAddress = 32'h100;
    #1;
    checks++;
    if (romEnable !== 1'b0) begin
      errors++;
      $display("FAIL redir_noissue got %b want 0", romEnable);
    end
    tick();
    redirectValid = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b0 || queueCount !== 3'd0) begin
      errors++;
      $display("FAIL redir_flush got %b/%0d want 0/0",
               outValid, queueCount);
    end
    checks++;
    if (currentAddress !== 32'h100 || romEnable !== 1'b1
        || romAddress !== 32'h100) begin
      errors++;
      $display("FAIL redir_target got %h/%b want 00000100/1",
               romAddress, romEnable);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (flushCount !== 16'd1) begin
      errors++;
      $display("FAIL redir_flushcnt got %0d want 1", flushCount);
    end
`endif
    outReady = 1'b1;
    tick();
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("FAIL redir_stale got %b want 0", outValid);
    end
    tick();
    checks++;
    if (outValid !== 1'b1 || outAddress !== 32'h100
        || outInstr !== 32'hA5A5_0100) begin
      errors++;
      $display("FAIL redir_first got %b/%h/%h want 1/00000100/a5a50100",
               outValid, outAddress, outInstr);
    end
  endtask

  task automatic test_pcwrite();
    do_reset();
    Reset = 1'b1;
    PCWrite = 1'b1;
    outReady = 1'b0;
    tick();
    tick();
    tick();
    PCWrite = 1'b0;
    outReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (currentAddress !== 32'hC || romEnable !== 1'b0) begin
        errors++;
        $display("FAIL hold_pc%0d got %h/%b want 0000000c/0",
                 k, currentAddress, romEnable);
      end
      checks++;
      if (outValid !== 1'b1 || outAddress !== 32'(4 * k)) begin
        errors++;
        $display("FAIL hold_pop%0d got %b/%h want 1/%h",
                 k, outValid, outAddress, 32'(4 * k));
      end
      tick();
    end
    checks++;
    if (queueCount !== 3'd0 || outValid !== 1'b0
        || currentAddress !== 32'hC) begin
      errors++;
      $display("FAIL hold_drained got %0d/%b/%h want 0/0/0000000c",
               queueCount, outValid, currentAddress);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp [4];
    exp[0] = 32'hFFFF_FFF8;
    exp[1] = 32'hFFFF_FFFC;
    exp[2] = 32'h0000_0000;
    exp[3] = 32'h0000_0004;
    do_reset();
    Reset = 1'b1;
    PCWrite = 1'b1;
    outReady = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (out2Valid !== 1'b1 || out2Addr !== exp[k]
          || out2Instr !== (exp[k] ^ 32'hA5A5_0000)) begin
        errors++;
        $display("FAIL wrap%0d got %b/%h/%h want 1/%h",
                 k, out2Valid, out2Addr, out2Instr, exp[k]);
      end
      tick();
    end
  endtask

  task automatic test_midreset();
    do_reset();
    Reset = 1'b1;
    PCWrite = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (queueCount !== 3'd0 || outValid !== 1'b0
        || currentAddress !== 32'h0 || romEnable !== 1'b0) begin
      errors++;
      $display("FAIL midrst got %0d/%b/%h/%b want 0/0/0/0",
               queueCount, outValid, currentAddress, romEnable);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (romEnable !== 1'b1 || romAddress !== 32'h0) begin
      errors++;
      $display("FAIL midrst_issue got %b/%h want 1/0",
               romEnable, romAddress);
    end
    tick();
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drop got %b want 0", outValid);
    end
    tick();
    checks++;
    if (outValid !== 1'b1 || outAddress !== 32'h0) begin
      errors++;
      $display("FAIL midrst_first got %b/%h want 1/0",
               outValid, outAddress);
    end
  endtask

  initial begin
    romData = '0;
    rom2Data = '0;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_pcwrite();
    test_wrap();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
